// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer: enables, load-use bubbles, branch flush, HLT drain.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              id_is_hlt,
  input  logic              id_use_a,
  input  logic [2:0]        id_src_a,
  input  logic              id_use_b,
  input  logic [2:0]        id_src_b,
  input  logic              ex_is_ld,
  input  logic [2:0]        ex_dst,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [STAGES-1:0] stage_valid,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [STAGES-1:0]   r_valid;
  logic [STAGES-1:0]   w_valid_next;
  logic                w_lu;
  logic                w_br;
  logic                w_hl;

  assign w_lu = ex_is_ld & r_valid[2] & r_valid[1] &
                ((id_use_a & (id_src_a == ex_dst)) | (id_use_b & (id_src_b == ex_dst)));
  assign w_br = branch_taken & r_valid[2];
  assign w_hl = id_is_hlt & r_valid[1];

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    w_state_next = r_state;
    w_valid_next = '0;
    case (r_state)
      S_RUN, S_DRAIN: begin
        // Stages 3 and up always advance; low stages are overridden below.
        w_valid_next = {r_valid[STAGES-2:0], 1'b0};
        if (w_br) begin
          pc_en             = 1'b1;
          if_id_flush       = 1'b1;
          id_ex_bubble      = 1'b1;
          w_valid_next[2:0] = 3'b001;
          w_state_next      = S_RUN;
        end else if (r_state == S_DRAIN) begin
          if (w_valid_next[STAGES-1:1] == '0) w_state_next = S_HALTED;
        end else if (w_hl) begin
          if_id_flush     = 1'b1;
          w_valid_next[1] = 1'b0;
          w_state_next    = S_DRAIN;
        end else if (w_lu) begin
          id_ex_bubble      = 1'b1;
          w_valid_next[2]   = 1'b0;
          w_valid_next[1:0] = r_valid[1:0];
        end else begin
          pc_en           = 1'b1;
          if_id_en        = 1'b1;
          w_valid_next[0] = 1'b1;
        end
      end
      default: begin
        if (start) w_state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
    end
  end

  assign stage_valid = r_valid;
  assign running     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign halted      = (r_state == S_HALTED);

`ifdef PIPE_PERF_EN
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // A stall only counts when no branch or HLT outranks the hazard.
  assign w_stall_evt = (r_state == S_RUN) & w_lu & ~w_br & ~w_hl;
  assign w_flush_evt = running & w_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (r_valid[STAGES-1] && (r_retired_cnt != '1)) r_retired_cnt <= r_retired_cnt + 1'b1;
      if (w_stall_evt && (r_stall_cnt != '1))         r_stall_cnt   <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1))         r_flush_cnt   <= r_flush_cnt + 1'b1;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule
